// File: rtl/arb_mux_pkg.sv
// Shared definitions for the arb_mux slice: select-mode encodings and clog2.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package arb_mux_pkg;

   localparam logic MODE_RR    = 1'b0;   // fair round-robin over in_valid
   localparam logic MODE_FIXED = 1'b1;   // serve only the channel on sel

   // Ceiling log2; used to size select and channel-ID fields.
   function automatic int clog2(input int n);
      int r;
      int v;
      r = 0;
      v = n - 1;
      while (v > 0) begin
         r = r + 1;
         v = v / 2;
      end
      return r;
   endfunction

endpackage

// File: rtl/arb_mux_if.sv
// Producer/consumer bundle for arb_mux: N request channels in, one registered word out.
// Latency: n/a (wires only).
// Backpressure: out_ready from the consumer, in_ready (one-hot or zero) back to producers.
// Ports: in_data/in_valid/in_ready (producer side), mode/sel (selection sideband),
//        out_data/out_chan/out_valid/out_ready (consumer side).
interface arb_mux_if
   import arb_mux_pkg::*;
#(
   parameter int SIZE     = 8,
   parameter int CHANNELS = 16
);
   localparam int SELW = clog2(CHANNELS);

   logic [CHANNELS*SIZE-1:0] in_data;
   logic [CHANNELS-1:0]      in_valid;
   logic [CHANNELS-1:0]      in_ready;
   logic                     mode;
   logic [SELW-1:0]          sel;
   logic [SIZE-1:0]          out_data;
   logic [SELW-1:0]          out_chan;
   logic                     out_valid;
   logic                     out_ready;

   // Environment side: drives requests, sideband and consumer ready.
   modport master (
      output in_data, in_valid, mode, sel, out_ready,
      input  in_ready, out_data, out_chan, out_valid
   );

   // Mux side.
   modport slave (
      input  in_data, in_valid, mode, sel, out_ready,
      output in_ready, out_data, out_chan, out_valid
   );

endinterface

// File: rtl/arb_mux_rr_pick.sv
// Rotate-priority finder: first set req bit searching from ptr+1, wrapping modulo CHANNELS.
// Latency: combinational.
// Backpressure: none (pure function of req and ptr).
// Ports: req (requests), ptr (last served channel), grant (winning index), found (any winner).
module rr_pick #(
   parameter int CHANNELS = 16,
   parameter int SELW     = 4
) (
   input  logic [CHANNELS-1:0] req,
   input  logic [SELW-1:0]     ptr,
   output logic [SELW-1:0]     grant,
   output logic                found
);

   localparam int NP = 1 << SELW;

   // Padding to a power of two lets every SELW-bit index be in range.
   logic [NP-1:0] req_pad;
   assign req_pad = NP'(req);

   always_comb begin
      int          idx;
      logic [SELW-1:0] idx_s;
      grant = '0;
      found = 1'b0;
      idx   = 0;
      idx_s = '0;
      // Walk offsets from farthest to nearest so the nearest request wins last.
      // Offset CHANNELS lands back on ptr itself: a lone requester at ptr is still served.
      for (int i = CHANNELS; i >= 1; i--) begin
         idx = int'(ptr) + i;
         if (idx >= CHANNELS) begin
            idx = idx - CHANNELS;
         end
         idx_s = idx[SELW-1:0];
         if (req_pad[idx_s]) begin
            grant = idx_s;
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/arb_mux.sv
// N-channel registered mux with round-robin or fixed-select arbitration.
// Latency: 1 cycle from accept to out_valid; 1 word/cycle with consume and load in the same edge.
// Backpressure: out_valid && !out_ready freezes the output word and drops every in_ready.
// Ports: clk, rst (async, active-high), bus (arb_mux_if.slave: in_data/in_valid/in_ready,
//        mode/sel, out_data/out_chan/out_valid/out_ready).
module arb_mux
   import arb_mux_pkg::*;
#(
   parameter int SIZE     = 8,
   parameter int CHANNELS = 16
) (
   input logic       clk,
   input logic       rst,
   arb_mux_if.slave  bus
);

   localparam int SELW = clog2(CHANNELS);
   localparam int NP   = 1 << SELW;

   logic                ld;
   logic                xfer;
   logic                grant_found;
   logic [SELW-1:0]     grant_idx;
   logic                rr_found;
   logic [SELW-1:0]     rr_grant;
   logic [NP-1:0]       valid_pad;
   logic [SIZE-1:0]     data_arr [NP];
   logic [CHANNELS-1:0] rdy;

   logic                valid_q;
   logic [SIZE-1:0]     data_q;
   logic [SELW-1:0]     chan_q;
   logic [SELW-1:0]     ptr_q;

   // Output register may take a new word when empty or being drained this cycle.
   assign ld = !valid_q || bus.out_ready;

   // Zero padding means an out-of-range sel reads a 0 request and a 0 data word, never X.
   assign valid_pad = NP'(bus.in_valid);

   for (genvar k = 0; k < NP; k++) begin : g_data
      if (k < CHANNELS) begin : g_real
         assign data_arr[k] = bus.in_data[k*SIZE +: SIZE];
      end else begin : g_pad
         assign data_arr[k] = '0;
      end
   end

   rr_pick #(
      .CHANNELS (CHANNELS),
      .SELW     (SELW)
   ) u_pick (
      .req   (bus.in_valid),
      .ptr   (ptr_q),
      .grant (rr_grant),
      .found (rr_found)
   );

   always_comb begin
      grant_idx   = rr_grant;
      grant_found = rr_found;
      if (bus.mode == MODE_FIXED) begin
         grant_idx   = bus.sel;
         grant_found = valid_pad[bus.sel];
      end
   end

   // The granted channel is always valid, so an accept is simply grant && ld.
   assign xfer = grant_found && ld && !rst;

   always_comb begin
      rdy = '0;
      for (int k = 0; k < CHANNELS; k++) begin
         rdy[k] = xfer && (grant_idx == SELW'(k));
      end
   end

   assign bus.in_ready = rdy;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         chan_q  <= '0;
         ptr_q   <= SELW'(CHANNELS - 1);   // first round-robin search starts at channel 0
      end else if (ld) begin
         if (grant_found) begin
            valid_q <= 1'b1;
            data_q  <= data_arr[grant_idx];
            chan_q  <= grant_idx;
            ptr_q   <= grant_idx;          // tracked in fixed mode too, so round-robin resumes after it
         end else begin
            valid_q <= 1'b0;
         end
      end
   end

   assign bus.out_valid = valid_q;
   assign bus.out_data  = data_q;
   assign bus.out_chan  = chan_q;

endmodule

// File: tb/tb_arb_mux.sv
module tb_arb_mux;
   import arb_mux_pkg::*;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   arb_mux_if #(.SIZE(8), .CHANNELS(16)) bus16 ();
   arb_mux_if #(.SIZE(8), .CHANNELS(5))  bus5 ();

   arb_mux #(.SIZE(8), .CHANNELS(16)) dut16 (
      .clk (clk),
      .rst (rst),
      .bus (bus16.slave)
   );

   arb_mux #(.SIZE(8), .CHANNELS(5)) dut5 (
      .clk (clk),
      .rst (rst),
      .bus (bus5.slave)
   );

   typedef struct {
      logic [15:0] vld;
      logic        mode;
      logic [3:0]  sel;
      logic        ordy;
      logic [15:0] e_rdy;
      logic        e_ov;
      logic [3:0]  e_chan;
      logic [7:0]  e_dat;
   } vec_t;

   vec_t tv[$];
   int   n_vec = 0;
   int   n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, need 0x%0h", name, act, exp);
      end
   endtask

   task automatic add(input logic [15:0] vld, input logic mode, input logic [3:0] sel,
                      input logic ordy, input logic [15:0] e_rdy, input logic e_ov,
                      input logic [3:0] e_chan, input logic [7:0] e_dat);
      vec_t v;
      v.vld = vld; v.mode = mode; v.sel = sel; v.ordy = ordy;
      v.e_rdy = e_rdy; v.e_ov = e_ov; v.e_chan = e_chan; v.e_dat = e_dat;
      tv.push_back(v);
   endtask

   task automatic step16(input vec_t v, input int i);
      @(negedge clk);
      bus16.in_valid  = v.vld;
      bus16.mode      = v.mode;
      bus16.sel       = v.sel;
      bus16.out_ready = v.ordy;
      #1;
      chk($sformatf("v%0d in_ready", i), 32'(bus16.in_ready), 32'(v.e_rdy));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d out_valid", i), 32'(bus16.out_valid), 32'(v.e_ov));
      chk($sformatf("v%0d out_chan", i), 32'(bus16.out_chan), 32'(v.e_chan));
      chk($sformatf("v%0d out_data", i), 32'(bus16.out_data), 32'(v.e_dat));
   endtask

   task automatic step5(input string tag, input logic [4:0] vld, input logic mode,
                        input logic [2:0] sel, input logic [4:0] e_rdy, input logic e_ov,
                        input logic [2:0] e_chan, input logic [7:0] e_dat);
      @(negedge clk);
      bus5.in_valid  = vld;
      bus5.mode      = mode;
      bus5.sel       = sel;
      bus5.out_ready = 1'b1;
      #1;
      chk({tag, " in_ready"}, 32'(bus5.in_ready), 32'(e_rdy));
      @(posedge clk);
      #1;
      chk({tag, " out_valid"}, 32'(bus5.out_valid), 32'(e_ov));
      chk({tag, " out_chan"}, 32'(bus5.out_chan), 32'(e_chan));
      chk({tag, " out_data"}, 32'(bus5.out_data), 32'(e_dat));
      chk({tag, " no X"}, 32'($isunknown({bus5.out_data, bus5.out_chan,
                                          bus5.out_valid, bus5.in_ready})), 32'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      for (int k = 0; k < 16; k++) bus16.in_data[k*8 +: 8] = 8'(8'h10 + k);
      for (int k = 0; k < 5; k++)  bus5.in_data[k*8 +: 8]  = 8'(8'h20 + k);
      bus16.in_valid = 16'hFFFF; bus16.mode = MODE_RR; bus16.sel = '0; bus16.out_ready = 1'b1;
      bus5.in_valid  = '0;       bus5.mode  = MODE_RR; bus5.sel  = '0; bus5.out_ready  = 1'b1;
      rst = 1'b1;

      // Reset state; requests are pending but must not be accepted while rst is high.
      #1;
      chk("reset in_ready", 32'(bus16.in_ready), 32'(0));
      chk("reset out_valid", 32'(bus16.out_valid), 32'(0));
      chk("reset out_data", 32'(bus16.out_data), 32'(0));
      chk("reset out_chan", 32'(bus16.out_chan), 32'(0));
      bus16.in_valid = '0;
      @(negedge clk);
      rst = 1'b0;

      // Full round-robin sweep 0..15 then wrap to 0.
      for (int i = 0; i < 17; i++)
         add(16'hFFFF, MODE_RR, 4'd0, 1'b1, 16'(1 << (i % 16)), 1'b1, 4'(i % 16), 8'(8'h10 + i % 16));
      // Park ptr at 12, then only 3 and 12 compete.
      add(16'h1000, MODE_RR, 4'd0, 1'b1, 16'h1000, 1'b1, 4'd12, 8'h1C);
      add(16'h1008, MODE_RR, 4'd0, 1'b1, 16'h0008, 1'b1, 4'd3,  8'h13);
      add(16'h1008, MODE_RR, 4'd0, 1'b1, 16'h1000, 1'b1, 4'd12, 8'h1C);
      add(16'h1008, MODE_RR, 4'd0, 1'b1, 16'h0008, 1'b1, 4'd3,  8'h13);
      add(16'h1008, MODE_RR, 4'd0, 1'b1, 16'h1000, 1'b1, 4'd12, 8'h1C);
      // Fixed select 5, then channel 5 drops its request.
      add(16'hFFFF, MODE_FIXED, 4'd5, 1'b1, 16'h0020, 1'b1, 4'd5, 8'h15);
      add(16'hFFFF, MODE_FIXED, 4'd5, 1'b1, 16'h0020, 1'b1, 4'd5, 8'h15);
      add(16'hFFFF, MODE_FIXED, 4'd5, 1'b1, 16'h0020, 1'b1, 4'd5, 8'h15);
      add(16'hFFDF, MODE_FIXED, 4'd5, 1'b1, 16'h0000, 1'b0, 4'd5, 8'h15);
      // Back to round-robin: resumes after 5.
      add(16'hFFFF, MODE_RR, 4'd0, 1'b1, 16'h0040, 1'b1, 4'd6, 8'h16);
      // Backpressure for 4 cycles, then consume and load in one edge.
      for (int i = 0; i < 4; i++)
         add(16'hFFFF, MODE_RR, 4'd0, 1'b0, 16'h0000, 1'b1, 4'd6, 8'h16);
      add(16'hFFFF, MODE_RR, 4'd0, 1'b1, 16'h0080, 1'b1, 4'd7, 8'h17);
      add(16'hFFFF, MODE_RR, 4'd0, 1'b1, 16'h0100, 1'b1, 4'd8, 8'h18);
      // Lone requester sitting exactly at ptr.
      add(16'h0100, MODE_RR, 4'd0, 1'b1, 16'h0100, 1'b1, 4'd8, 8'h18);
      add(16'h0100, MODE_RR, 4'd0, 1'b1, 16'h0100, 1'b1, 4'd8, 8'h18);
      // Idle bubble, then an empty register loads even with out_ready low.
      add(16'h0000, MODE_RR, 4'd0, 1'b1, 16'h0000, 1'b0, 4'd8, 8'h18);
      add(16'h0001, MODE_RR, 4'd0, 1'b0, 16'h0001, 1'b1, 4'd0, 8'h10);
      add(16'h0001, MODE_RR, 4'd0, 1'b0, 16'h0000, 1'b1, 4'd0, 8'h10);
      // Highest fixed select, then wrap 15 -> 0 in round-robin.
      add(16'hFFFF, MODE_FIXED, 4'd15, 1'b1, 16'h8000, 1'b1, 4'd15, 8'h1F);
      add(16'h0001, MODE_RR, 4'd0, 1'b1, 16'h0001, 1'b1, 4'd0, 8'h10);
      add(16'h0004, MODE_RR, 4'd0, 1'b1, 16'h0004, 1'b1, 4'd2, 8'h12);

      for (int i = 0; i < tv.size(); i++) step16(tv[i], i);

      // Asynchronous reset between edges with a word held and a request pending.
      #2;
      rst = 1'b1;
      #1;
      chk("async rst out_valid", 32'(bus16.out_valid), 32'(0));
      chk("async rst out_data", 32'(bus16.out_data), 32'(0));
      chk("async rst out_chan", 32'(bus16.out_chan), 32'(0));
      chk("async rst in_ready", 32'(bus16.in_ready), 32'(0));
      @(negedge clk);
      rst = 1'b0;
      bus16.in_valid  = 16'h0810;
      bus16.mode      = MODE_RR;
      bus16.out_ready = 1'b1;
      #1;
      chk("post rst in_ready", 32'(bus16.in_ready), 32'(16'h0010));
      @(posedge clk);
      #1;
      chk("post rst out_valid", 32'(bus16.out_valid), 32'(1));
      chk("post rst out_chan", 32'(bus16.out_chan), 32'(4));
      chk("post rst out_data", 32'(bus16.out_data), 32'(8'h14));

      // Five-channel instance: out-of-range selects, top in-range select, rr wrap.
      step5("c5 sel6", 5'h1F, MODE_FIXED, 3'd6, 5'h00, 1'b0, 3'd0, 8'h00);
      step5("c5 sel5", 5'h1F, MODE_FIXED, 3'd5, 5'h00, 1'b0, 3'd0, 8'h00);
      step5("c5 sel7", 5'h1F, MODE_FIXED, 3'd7, 5'h00, 1'b0, 3'd0, 8'h00);
      step5("c5 sel4", 5'h1F, MODE_FIXED, 3'd4, 5'h10, 1'b1, 3'd4, 8'h24);
      for (int i = 0; i < 6; i++)
         step5($sformatf("c5 rr%0d", i), 5'h1F, MODE_RR, 3'd0,
               5'(1 << (i % 5)), 1'b1, 3'(i % 5), 8'(8'h20 + i % 5));
      step5("c5 sel6 drop", 5'h1F, MODE_FIXED, 3'd6, 5'h00, 1'b0, 3'd0, 8'h20);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/arb_mux.md
# arb_mux

Parametrised N-channel registered multiplexer with valid/ready handshakes and built-in arbitration. It generalises the combinational 16:1 select mux. Any channel count and data width are supported, and two selection modes are provided: fair round-robin, or a fixed select from a sideband port. It sits between multiple producers and one consumer and adds one cycle of latency at full throughput.

## Interface
Parameters:
- SIZE, 8, data width per channel (≥1)
- CHANNELS, 16, number of input channels (≥2, need not be a power of two)
- SELW, derived localparam = clog2(CHANNELS), width of select and channel-ID fields

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset; asynchronous, active-high
- in_data  input  CHANNELS*SIZE  flattened channel data; channel k occupies bits [k*SIZE +: SIZE]
- in_valid  input  CHANNELS  per-channel request
- in_ready  output  CHANNELS  per-channel accept, one-hot or zero
- mode  input  1  0 = round-robin, 1 = fixed select
- sel  input  SELW  channel index used when mode=1
- out_data  output  SIZE  registered selected data
- out_chan  output  SELW  index of the channel that supplied out_data
- out_valid  output  1  output register holds a word
- out_ready  input  1  consumer accepts the word

## Operation
- Load enable: `ld = !out_valid || out_ready`.
- Grant is combinational each cycle. At most one channel is granted.
  - Round-robin (mode=0): search in_valid starting at `ptr+1`, wrapping modulo CHANNELS. The first set bit is granted.
  - Fixed (mode=1): grant `sel` only if `sel < CHANNELS` and `in_valid[sel]`. Otherwise there is no grant. Out-of-range sel never grants and never produces X.
- Handshake:
  - `in_ready[g] = ld` for the granted channel g; all other in_ready bits are 0.
  - A transfer happens on channel g when `in_valid[g] && in_ready[g]`.
- On a transfer, the output register loads `out_data <= in_data[g]`, `out_chan <= g`, `out_valid <= 1`, and `ptr <= g`. ptr is updated in both modes, so round-robin resumes after the last served channel.
- If ld is true and there is no grant: `out_valid <= 0`; out_data and out_chan keep their values.
- If `out_valid && !out_ready`: out_data, out_chan and out_valid hold stable, all in_ready bits are 0, and ptr holds.
- A mode or sel change takes effect on the next grant evaluation. There is no flush, and a word already in the output register is unaffected.
- Fairness: in round-robin mode with all channels continuously valid and out_ready=1, each channel is served exactly once every CHANNELS cycles.

## Timing
- Reset (asynchronous assert, synchronous-safe release): out_valid=0, out_data=0, out_chan=0, ptr=CHANNELS-1. The first round-robin search therefore starts at channel 0.
- in_ready is 0 while rst is high.
- Latency: a word accepted at edge n appears on out_data/out_valid after edge n, and is consumed at the first later edge with out_ready=1.
- Throughput is 1 word/cycle. Simultaneous consume and load in the same cycle is required, with no bubble.
- in_ready depends combinationally on in_valid, mode, sel and out_ready. There is no combinational path from in_data to any output.
- Wrap-around: if ptr=CHANNELS-1 and channel 0 is valid, channel 0 is granted.
- Single requester: a lone valid channel is granted every cycle, whatever the value of ptr.
- Reset mid-transfer: the held output word is discarded immediately and the in-flight accept is void.

## Structure
- Shared package/header holds:
  - the clog2 constant function
  - mode encodings MODE_RR=1'b0 and MODE_FIXED=1'b1
- Sub-module `rr_pick`: combinational rotate-priority finder. It is parametrised on CHANNELS; inputs are req and ptr, outputs are grant index and found flag. The fixed-mode path bypasses it.
- Top level: grant mux, output register, ptr register, in_ready decode.

## Test plan
1. Reset, then CHANNELS=16, SIZE=8, mode=0, all in_valid=1, out_ready=1, in_data[k]=k+8'h10 → out_chan sequence 0,1,…,15,0 on consecutive cycles, and out_data=out_chan+8'h10.
2. Round-robin, only channels 3 and 12 valid, ptr starting at 12 → grants alternate 3,12,3,…; wrap from 12 goes to 3.
3. mode=1, sel=5, in_valid=16'hFFFF → only in_ready[5] is high and out_chan=5 every cycle. Setting sel=5 with in_valid[5]=0 → out_valid drops to 0 after one cycle.
4. Backpressure: out_valid=1 with out_ready=0 for 4 cycles → out_data and out_chan stable, in_ready=0. Releasing out_ready → word consumed and next channel loaded in the same edge.
5. CHANNELS=5, mode=1, sel=6 → no grant, out_valid=0, no X on any output.
6. Assert rst asynchronously mid-stream, between edges → out_valid=0 and out_data=0 immediately. After release, the first grant goes to the lowest valid channel.
